// File: rtl/mem_bus_arb.sv
// Two-port line arbiter: I-port and D-port line transfers run as BEATS-beat bursts on one BUS_W bus.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed D-over-I priority.
module mem_bus_arb #(
  parameter int unsigned LINE_W = 1024,
  parameter int unsigned BUS_W  = 64,
  parameter int unsigned BEATS  = LINE_W / BUS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction port
  input  logic [63:0]       b_addr_i,
  input  logic              b_rd_i,
  output logic [LINE_W-1:0] b_data_i,
  output logic              b_dv_i,
  // Data port
  input  logic [63:0]       b_addr,
  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_data_out,
  output logic [LINE_W-1:0] b_data_in,
  output logic              b_dv,
  // Memory side
  output logic [63:0]       m_addr,
  output logic              m_req,
  output logic              m_we,
  output logic [BUS_W-1:0]  m_wdata,
  input  logic [BUS_W-1:0]  m_rdata,
  input  logic              m_ack
);

  localparam int unsigned BeatW   = $clog2(BEATS);
  localparam int unsigned ByteOff = $clog2(BUS_W / 8);
  localparam int unsigned LineOff = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {StIdle, StBurst, StDone, StGap} state_e;

  state_e            state_q;
  logic [BeatW-1:0]  beat_q;
  logic [63:0]       line_q;
  logic              we_q;
  logic              own_d_q;
  logic [LINE_W-1:0] buf_q;

  logic              d_req;
  logic              grant_any;
  logic              grant_d;
  logic              grant_we;
  logic [63:0]       req_line;
  logic [BeatW-1:0]  beat_nx;
  logic              last_beat;
  logic [63:0]       beat_off_nx;

`ifdef ARB_RR_EN
  logic last_d_q;
`endif

  always_comb begin
    d_req     = b_rd | b_wr;
    grant_any = d_req | b_rd_i;
`ifdef ARB_RR_EN
    // On contention the port not granted last wins.
    grant_d   = d_req & ~(b_rd_i & last_d_q);
`else
    grant_d   = d_req;
`endif
    // A D-port write wins over a simultaneous D-port read.
    grant_we  = grant_d & b_wr;
    req_line  = (grant_d ? b_addr : b_addr_i) & ~((64'd1 << LineOff) - 64'd1);
    beat_nx   = beat_q + BeatW'(1);
    last_beat = (beat_q == BeatW'(BEATS - 1));
    beat_off_nx = 64'(beat_nx) << ByteOff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      line_q    <= '0;
      we_q      <= 1'b0;
      own_d_q   <= 1'b0;
      buf_q     <= '0;
      m_addr    <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_wdata   <= '0;
      b_dv      <= 1'b0;
      b_dv_i    <= 1'b0;
      b_data_i  <= '0;
      b_data_in <= '0;
`ifdef ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      b_dv   <= 1'b0;
      b_dv_i <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            state_q <= StBurst;
            line_q  <= req_line;
            we_q    <= grant_we;
            own_d_q <= grant_d;
            beat_q  <= '0;
            if (grant_we) buf_q <= b_data_out;
            m_req   <= 1'b1;
            m_we    <= grant_we;
            m_addr  <= req_line;
            m_wdata <= grant_we ? b_data_out[BUS_W-1:0] : '0;
`ifdef ARB_RR_EN
            last_d_q <= grant_d;
`endif
          end
        end
        StBurst: begin
          // Without an ack every m_* output holds its value.
          if (m_ack) begin
            if (!we_q) buf_q[beat_q*BUS_W +: BUS_W] <= m_rdata;
            if (last_beat) begin
              state_q <= StDone;
              beat_q  <= '0;
              m_req   <= 1'b0;
              m_we    <= 1'b0;
            end else begin
              beat_q  <= beat_nx;
              m_addr  <= line_q | beat_off_nx;
              m_wdata <= we_q ? buf_q[beat_nx*BUS_W +: BUS_W] : '0;
            end
          end
        end
        StDone: begin
          state_q <= StGap;
          if (own_d_q) begin
            b_dv <= 1'b1;
            if (!we_q) b_data_in <= buf_q;
          end else begin
            b_dv_i   <= 1'b1;
            b_data_i <= buf_q;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed self-checking bench for mem_bus_arb: table of single-port transfers plus
// hand-written contention, read+write, reset and idle sequences.
module tb_mem_bus_arb;
  localparam int unsigned LINE_W = 1024;
  localparam int unsigned BUS_W  = 64;
  localparam int unsigned BEATS  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [63:0]       b_addr_i = '0;
  logic              b_rd_i = 1'b0;
  logic [LINE_W-1:0] b_data_i;
  logic              b_dv_i;
  logic [63:0]       b_addr = '0;
  logic              b_rd = 1'b0;
  logic              b_wr = 1'b0;
  logic [LINE_W-1:0] b_data_out = '0;
  logic [LINE_W-1:0] b_data_in;
  logic              b_dv;
  logic [63:0]       m_addr;
  logic              m_req;
  logic              m_we;
  logic [BUS_W-1:0]  m_wdata;
  logic [BUS_W-1:0]  m_rdata = '0;
  logic              m_ack = 1'b0;

  mem_bus_arb #(.LINE_W(LINE_W), .BUS_W(BUS_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .b_addr_i   (b_addr_i),
    .b_rd_i     (b_rd_i),
    .b_data_i   (b_data_i),
    .b_dv_i     (b_dv_i),
    .b_addr     (b_addr),
    .b_rd       (b_rd),
    .b_wr       (b_wr),
    .b_data_out (b_data_out),
    .b_data_in  (b_data_in),
    .b_dv       (b_dv),
    .m_addr     (m_addr),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ack      (m_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [LINE_W-1:0] exp_i = '0;
  logic [LINE_W-1:0] exp_d = '0;

  typedef struct {
    logic        port_d;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] base;
    logic [63:0] seed;
    bit          stall;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < BEATS; k++) begin
        if (act[k*64 +: 64] !== exp[k*64 +: 64]) begin
          $display("FAIL %s word %0d: got %h want %h", name, k, act[k*64 +: 64],
                   exp[k*64 +: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] seed);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*64 +: 64] = seed + 64'(k);
    return l;
  endfunction

  // Waits for a burst, serves nbeats beats (word k = seed+k), then for a full burst checks
  // the DONE cycle and the dv pulse; returns at the negedge where dv is visible.
  task automatic serve(input string tag, input logic exp_d_own, input logic exp_we,
                       input logic [63:0] base, input logic [63:0] seed, input bit stall,
                       input int nbeats, output int t_req, output int t_dv);
    int k;
    int ph;
    int guard;
    logic ack;
    t_req = -1;
    t_dv  = -1;
    guard = 0;
    while (m_req !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " grant"}, 64'(m_req), 64'd1);
    if (m_req !== 1'b1) return;
    t_req = cyc;
    k = 0;
    ph = 0;
    guard = 0;
    while (k < nbeats && guard < 100) begin
      chk({tag, " m_addr"}, m_addr, base + 64'(k) * 64'd8);
      chk({tag, " m_we"}, 64'(m_we), 64'(exp_we));
      chk({tag, " m_req"}, 64'(m_req), 64'd1);
      chk({tag, " dv in burst"}, 64'({b_dv, b_dv_i}), 64'd0);
      if (exp_we) chk({tag, " m_wdata"}, m_wdata, seed + 64'(k));
      ack = !(stall && (ph % 2 == 1));
      m_ack = ack;
      m_rdata = seed + 64'(k);
      @(negedge clk);
      ph++;
      guard++;
      if (ack) k++;
    end
    m_ack = 1'b0;
    m_rdata = '0;
    chk({tag, " beats"}, 64'(k), 64'(nbeats));
    if (nbeats < BEATS) return;
    chk({tag, " done m_req"}, 64'(m_req), 64'd0);
    chk({tag, " done dv"}, 64'({b_dv, b_dv_i}), 64'd0);
    @(negedge clk);
    chk({tag, " dv"}, 64'(exp_d_own ? b_dv : b_dv_i), 64'd1);
    chk({tag, " other dv"}, 64'(exp_d_own ? b_dv_i : b_dv), 64'd0);
    t_dv = cyc;
  endtask

  task automatic post_dv(input string tag);
    @(negedge clk);
    chk({tag, " dv width"}, 64'({b_dv, b_dv_i}), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, tr, td, td_d;
    vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_1000_0045, 64'h0000_0000_1000_0000, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_2000, 64'hA0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 64'h0000_2000_0000_1234, 64'h0000_2000_0000_1200, 64'h5500, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF80, 64'h77_0000, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 64'h0000_0000_0000_0047, 64'h0, 64'h1000, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst m_req", 64'(m_req), 64'd0);
    chk("rst m_we", 64'(m_we), 64'd0);
    chk("rst dv", 64'({b_dv, b_dv_i}), 64'd0);
    chk("rst m_addr", m_addr, 64'd0);
    chk("rst m_wdata", m_wdata, 64'd0);
    chk_line("rst b_data_i", b_data_i, '0);
    chk_line("rst b_data_in", b_data_in, '0);
    rst_n = 1'b1;

    // Idle: nothing moves for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle m_req", 64'(m_req), 64'd0);
      chk("idle dv", 64'({b_dv, b_dv_i}), 64'd0);
      chk("idle m_addr", m_addr, 64'd0);
    end
    chk_line("idle b_data_i", b_data_i, '0);
    chk_line("idle b_data_in", b_data_in, '0);

    // Single-port transfers
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].port_d) begin
        b_addr = vecs[v].addr;
        b_wr = vecs[v].wr;
        b_rd = !vecs[v].wr;
        b_data_out = vecs[v].wr ? mk_line(vecs[v].seed) : '0;
      end else begin
        b_addr_i = vecs[v].addr;
        b_rd_i = 1'b1;
      end
      t0 = cyc;
      serve($sformatf("vec%0d", v), vecs[v].port_d, vecs[v].wr, vecs[v].base, vecs[v].seed,
            vecs[v].stall, BEATS, tr, td);
      b_rd = 1'b0;
      b_wr = 1'b0;
      b_rd_i = 1'b0;
      if (!vecs[v].wr) begin
        if (vecs[v].port_d) exp_d = mk_line(vecs[v].seed);
        else exp_i = mk_line(vecs[v].seed);
      end
      chk_line($sformatf("vec%0d b_data_i", v), b_data_i, exp_i);
      chk_line($sformatf("vec%0d b_data_in", v), b_data_in, exp_d);
      if (!vecs[v].stall) begin
        chk($sformatf("vec%0d req latency", v), 64'(tr - t0), 64'd1);
        chk($sformatf("vec%0d dv latency", v), 64'(td - t0), 64'd18);
      end
      post_dv($sformatf("vec%0d", v));
    end

    // Contention: D first, I after the gap, 19 cycles between dv pulses
    b_addr = 64'h4000;
    b_rd = 1'b1;
    b_addr_i = 64'h5000;
    b_rd_i = 1'b1;
    serve("cont1 d", 1'b1, 1'b0, 64'h4000, 64'h4400, 1'b0, BEATS, tr, td_d);
    b_rd = 1'b0;
    exp_d = mk_line(64'h4400);
    chk_line("cont1 b_data_in", b_data_in, exp_d);
    post_dv("cont1 d");
    serve("cont1 i", 1'b0, 1'b0, 64'h5000, 64'h5500, 1'b0, BEATS, tr, td);
    b_rd_i = 1'b0;
    exp_i = mk_line(64'h5500);
    chk_line("cont1 b_data_i", b_data_i, exp_i);
    chk("cont1 dv spacing", 64'(td - td_d), 64'd19);
    post_dv("cont1 i");

    // Second pair, D keeps requesting after its dv
    b_addr = 64'h7000;
    b_rd = 1'b1;
    b_addr_i = 64'h8000;
    b_rd_i = 1'b1;
    serve("cont2 d", 1'b1, 1'b0, 64'h7000, 64'h7700, 1'b0, BEATS, tr, td);
    b_addr = 64'h7080;
    exp_d = mk_line(64'h7700);
    chk_line("cont2 b_data_in", b_data_in, exp_d);
    post_dv("cont2 d");
`ifdef ARB_RR_EN
    serve("cont2 i", 1'b0, 1'b0, 64'h8000, 64'h8800, 1'b0, BEATS, tr, td);
    b_rd_i = 1'b0;
    exp_i = mk_line(64'h8800);
    post_dv("cont2 i");
    serve("cont2 d2", 1'b1, 1'b0, 64'h7080, 64'h7780, 1'b0, BEATS, tr, td);
    b_rd = 1'b0;
    exp_d = mk_line(64'h7780);
    post_dv("cont2 d2");
`else
    serve("cont2 d2", 1'b1, 1'b0, 64'h7080, 64'h7780, 1'b0, BEATS, tr, td);
    b_rd = 1'b0;
    exp_d = mk_line(64'h7780);
    post_dv("cont2 d2");
    serve("cont2 i", 1'b0, 1'b0, 64'h8000, 64'h8800, 1'b0, BEATS, tr, td);
    b_rd_i = 1'b0;
    exp_i = mk_line(64'h8800);
    post_dv("cont2 i");
`endif
    chk_line("cont2 b_data_i", b_data_i, exp_i);
    chk_line("cont2 b_data_in", b_data_in, exp_d);

    // Same-cycle read and write on the D-port: write first, then read
    b_addr = 64'h3000;
    b_data_out = mk_line(64'hB0);
    b_rd = 1'b1;
    b_wr = 1'b1;
    serve("rw wr", 1'b1, 1'b1, 64'h3000, 64'hB0, 1'b0, BEATS, tr, td);
    b_wr = 1'b0;
    chk_line("rw wr b_data_in", b_data_in, exp_d);
    post_dv("rw wr");
    serve("rw rd", 1'b1, 1'b0, 64'h3000, 64'hC0, 1'b0, BEATS, tr, td);
    b_rd = 1'b0;
    exp_d = mk_line(64'hC0);
    chk_line("rw rd b_data_in", b_data_in, exp_d);
    post_dv("rw rd");

    // Reset after beat 7 ack aborts the burst
    b_addr_i = 64'h6000;
    b_rd_i = 1'b1;
    serve("abort", 1'b0, 1'b0, 64'h6000, 64'h900, 1'b0, 8, tr, td);
    rst_n = 1'b0;
    #1;
    chk("abort m_req", 64'(m_req), 64'd0);
    chk("abort dv", 64'({b_dv, b_dv_i}), 64'd0);
    chk("abort m_addr", m_addr, 64'd0);
    chk_line("abort b_data_i", b_data_i, '0);
    chk_line("abort b_data_in", b_data_in, '0);
    exp_i = '0;
    exp_d = '0;
    @(negedge clk);
    @(negedge clk);
    chk("abort hold dv", 64'({b_dv, b_dv_i}), 64'd0);
    rst_n = 1'b1;
    serve("restart", 1'b0, 1'b0, 64'h6000, 64'h900, 1'b0, BEATS, tr, td);
    b_rd_i = 1'b0;
    exp_i = mk_line(64'h900);
    chk_line("restart b_data_i", b_data_i, exp_i);
    chk_line("restart b_data_in", b_data_in, exp_d);
    post_dv("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Sits directly downstream of the hart's two line-wide bus ports: the instruction port (b_*_i) and the data port (b_*).
- Arbitrates between the two ports and services each 1024-bit (128-byte) line transfer as a 16-beat burst on a single 64-bit memory-side bus.
- Assembles read lines before raising the requester's data-valid strobe.
- Serialises write lines beat by beat.

Parameters:
- LINE_W, 1024: hart-side line width in bits; must be a multiple of BUS_W.
- BUS_W, 64: memory-side data width in bits.
- BEATS, LINE_W/BUS_W (16): beats per line burst; derived, do not override.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- b_addr_i  in  64  I-port line address; bits [6:0] ignored
- b_rd_i  in  1  I-port read request, level
- b_data_i  out  1024  I-port read line
- b_dv_i  out  1  I-port data valid, 1-cycle pulse
- b_addr  in  64  D-port line address; bits [6:0] ignored
- b_rd  in  1  D-port read request, level
- b_wr  in  1  D-port write request, level
- b_data_out  in  1024  D-port write line
- b_data_in  out  1024  D-port read line
- b_dv  out  1  D-port done (read data valid or write complete), 1-cycle pulse
- m_addr  out  64  beat byte address
- m_req  out  1  beat request
- m_we  out  1  1 = write beat, 0 = read beat
- m_wdata  out  64  write beat data
- m_rdata  in  64  read beat data
- m_ack  in  1  beat accepted / read data valid this cycle

Behaviour:
- Reset (async assert):
  - Outputs m_req, m_we, b_dv, b_dv_i go to 0 immediately.
  - m_addr, m_wdata, b_data_i and b_data_in reset to 0.
  - FSM to IDLE, beat counter to 0.
  - Reset mid-burst aborts the burst; no dv is ever issued for it.
- FSM states:
  - IDLE: sample requests; the chosen request latches the line address {addr[63:7],7'b0}, the op, the owner and (for writes) b_data_out into a line buffer; next state BURST. No request: stay.
  - BURST: m_req=1. m_addr = {line[63:7], beat[3:0], 3'b0}. m_we = op. m_wdata = buffer[beat*64 +: 64]. Each cycle with m_ack=1 completes one beat: read beats store m_rdata into buffer[beat*64 +: 64], and beat increments. After the ack of beat 15, go to DONE. m_ack=0 holds all m_* outputs stable.
  - DONE: m_req=0. Pulse the owner's dv for exactly this cycle; for reads the owner's data output shows the assembled line. Next state GAP.
  - GAP: one dead cycle with no grant, so the requester can drop its level request after dv. Then IDLE.
- Read data outputs: b_data_i / b_data_in hold their last value until that port's next read completes. A write never alters b_data_in.
- Priority (default): D-port beats I-port.
- Simultaneous b_rd and b_wr on the D-port: the write is serviced first and its dv is the write's completion. If b_rd is still high on return to IDLE, the read is serviced next.
- Latency: request seen in IDLE at cycle 0 → first m_req at cycle 1 → with m_ack held high, dv at cycle 18. Back-to-back grants are 19 cycles apart.
- Request inputs are ignored outside IDLE; a request dropped mid-burst does not abort it.
- Beat counter wraps 15→0 only on the DONE transition; address low bits never carry into bit 7.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin. A 1-bit last-owner register, reset to I, is updated at each grant. When both ports request in IDLE, the port not granted last wins. A single requester always wins.
- Undefined: fixed D-over-I priority as above; the last-owner register is absent.

Test Plan:
- I read: b_rd_i=1, b_addr_i=64'h1000_0045, m_ack=1, m_rdata=beat index → m_addr steps 0x1000_0000..0x1000_0078 by 8; b_dv_i pulses at cycle 18; b_data_i[64*k+:64]=k; b_dv=0 throughout.
- D write with stalls: b_wr=1, b_addr=64'h2000, b_data_out word k = 64'hA0+k; m_ack=0 on odd cycles → each m_addr/m_wdata held until acked; 16 writes with m_we=1; single b_dv pulse; b_data_in unchanged.
- Contention: b_rd_i and b_rd both rise at cycle 0 → D serviced first; I granted after GAP; b_dv_i 19 cycles after b_dv. With ARB_RR_EN and reset last-owner=I: same stimulus, D first; a second simultaneous request pair then goes to I.
- Same-cycle b_rd and b_wr, addr 0x3000 → write burst (m_we=1), dv, GAP, then read burst on 0x3000; second dv carries the read line.
- Reset mid-burst: assert rst_n=0 after beat 7 ack → m_req=0 and b_dv=0 the same cycle; after release, a new I read completes normally from beat 0.
- Idle: no requests for 100 cycles → m_req=0, no dv pulses, outputs stable.
